// File: rtl/trans_layer_n.sv
// N-channel transaction layer: a main ingress FIFO routed by destination field into
// NUM_CH egress FIFOs, with almost-full backpressure, delivery counters and a control FSM.
module trans_layer_n #(
   parameter int DATA_SIZE = 12,
   parameter int NUM_CH    = 4,
   parameter int CH_BITS   = $clog2(NUM_CH),
   parameter int MAIN_ADDR = 3,
   parameter int CH_ADDR   = 2,
   parameter int CNT_W     = 6
) (
   input  logic                        clk,
   input  logic                        reset_L,
   input  logic                        init,
   input  logic [CH_ADDR:0]            th_almost_full,
   input  logic [CH_ADDR:0]            th_almost_empty,
   input  logic [DATA_SIZE-1:0]        data_in,
   input  logic                        push,
   input  logic [NUM_CH-1:0]           pop,
   output logic [NUM_CH*DATA_SIZE-1:0] data_out,
   output logic [NUM_CH-1:0]           valid_out,
   output logic [NUM_CH-1:0]           almost_full,
   output logic [NUM_CH-1:0]           almost_empty,
   output logic                        main_full,
   input  logic                        req,
   input  logic [CH_BITS-1:0]          idx,
   output logic [CNT_W-1:0]            data_out_cont,
   output logic                        valid_cont,
   output logic                        idle,
   output logic                        error
);
   localparam int MAIN_DEPTH = 1 << MAIN_ADDR;
   localparam int CH_DEPTH   = 1 << CH_ADDR;
   localparam logic [MAIN_ADDR:0] MAIN_FULL = (MAIN_ADDR+1)'(MAIN_DEPTH);
   localparam logic [CH_ADDR:0]   CH_FULL   = (CH_ADDR+1)'(CH_DEPTH);

   typedef enum logic [2:0] {S_RESET, S_INIT, S_IDLE, S_ACTIVE, S_ERROR} state_t;
   state_t state, state_nxt;

   logic [DATA_SIZE-1:0] main_mem [MAIN_DEPTH];
   logic [MAIN_ADDR-1:0] main_wr, main_rd;
   logic [MAIN_ADDR:0]   main_cnt, main_cnt_nxt;

   logic [DATA_SIZE-1:0] eg_mem [NUM_CH][CH_DEPTH];
   logic [CH_ADDR-1:0]   eg_wr [NUM_CH];
   logic [CH_ADDR-1:0]   eg_rd [NUM_CH];
   logic [CH_ADDR:0]     eg_cnt [NUM_CH];
   logic [CH_ADDR:0]     eg_cnt_nxt [NUM_CH];
   logic [CNT_W-1:0]     cont [NUM_CH];

   logic [CH_ADDR:0]     th_af, th_ae;
   logic [NUM_CH-1:0]    eg_empty, eg_full, af_raw, pop_ok;
   logic [DATA_SIZE-1:0] head;
   logic [CH_BITS-1:0]   dest;
   logic                 op_en, push_ok, route_ok, fault, any_busy;

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         eg_empty[i]     = (eg_cnt[i] == '0);
         eg_full[i]      = (eg_cnt[i] == CH_FULL);
         af_raw[i]       = (eg_cnt[i] >= th_af);
         almost_empty[i] = (eg_cnt[i] <= th_ae);
      end
   end

   // Loaded thresholds are 0 in RESET, which would make every channel look almost full.
   assign almost_full = (state == S_RESET) ? '0 : af_raw;
   assign main_full   = (main_cnt == MAIN_FULL);

   assign head     = main_mem[main_rd];
   assign dest     = head[DATA_SIZE-1 -: CH_BITS];
   assign op_en    = (state == S_IDLE) || (state == S_ACTIVE);
   assign push_ok  = op_en && push && !main_full;
   assign pop_ok   = {NUM_CH{op_en}} & pop & ~eg_empty;
   assign route_ok = op_en && (main_cnt != '0) && !eg_full[dest] && !af_raw[dest];
   assign fault    = op_en && ((push && main_full) || (|(pop & eg_empty)));

   // NOTE: every variable written in always_comb gets a value on every path; no latches.
   always_comb begin
      main_cnt_nxt = main_cnt + (MAIN_ADDR+1)'(push_ok) - (MAIN_ADDR+1)'(route_ok);
      any_busy     = (main_cnt_nxt != '0);
      for (int i = 0; i < NUM_CH; i++) begin
         eg_cnt_nxt[i] = eg_cnt[i] + (CH_ADDR+1)'(route_ok && (dest == CH_BITS'(i)))
                                   - (CH_ADDR+1)'(pop_ok[i]);
         any_busy = any_busy | (eg_cnt_nxt[i] != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_L) state <= S_RESET;
      else          state <= state_nxt;
   end

   // IDLE/ACTIVE are chosen from post-edge occupancy, so IDLE always means empty.
   always_comb begin
      state_nxt = state;
      case (state)
         S_RESET:  state_nxt = S_INIT;
         S_INIT:   if (!init) state_nxt = S_IDLE;
         S_IDLE, S_ACTIVE: begin
            if (fault)      state_nxt = S_ERROR;
            else if (init)  state_nxt = S_INIT;
            else            state_nxt = any_busy ? S_ACTIVE : S_IDLE;
         end
         S_ERROR:  state_nxt = S_ERROR;
         default:  state_nxt = S_RESET;
      endcase
   end

   always_comb begin
      idle  = (state == S_IDLE);
      error = (state == S_ERROR);
   end

   always_ff @(posedge clk) begin
      if (!reset_L) begin
         main_wr       <= '0;
         main_rd       <= '0;
         main_cnt      <= '0;
         th_af         <= '0;
         th_ae         <= '0;
         data_out      <= '0;
         valid_out     <= '0;
         data_out_cont <= '0;
         valid_cont    <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            eg_wr[i]  <= '0;
            eg_rd[i]  <= '0;
            eg_cnt[i] <= '0;
            cont[i]   <= '0;
         end
      end else begin
         if (state == S_INIT) begin
            th_af <= th_almost_full;
            th_ae <= th_almost_empty;
         end
         if (push_ok)  main_wr <= main_wr + 1'b1;
         if (route_ok) main_rd <= main_rd + 1'b1;
         main_cnt <= main_cnt_nxt;
         for (int i = 0; i < NUM_CH; i++) begin
            eg_cnt[i]    <= eg_cnt_nxt[i];
            valid_out[i] <= pop_ok[i];
            if (route_ok && (dest == CH_BITS'(i))) eg_wr[i] <= eg_wr[i] + 1'b1;
            if (pop_ok[i]) begin
               eg_rd[i] <= eg_rd[i] + 1'b1;
               data_out[i*DATA_SIZE +: DATA_SIZE] <= eg_mem[i][eg_rd[i]];
               cont[i]  <= cont[i] + 1'b1;
            end
         end
         valid_cont <= (state == S_IDLE) && req;
         if ((state == S_IDLE) && req) data_out_cont <= cont[idx];
      end
   end

   // NOTE: storage arrays are not reset; pointers and counts define which entries are live.
   always_ff @(posedge clk) begin
      if (push_ok)  main_mem[main_wr] <= data_in;
      if (route_ok) eg_mem[dest][eg_wr[dest]] <= head;
   end
endmodule

// File: tb/tb_trans_layer_n.sv
// Randomised and directed bench for trans_layer_n: queue-based reference model,
// per-channel scoreboards drained by a negedge monitor.
module tb_trans_layer_n;
   localparam int DS = 12, NUM_CH = 4, CH_BITS = 2, MAIN_ADDR = 3, CH_ADDR = 2, CNT_W = 6;
   localparam int MAIN_DEPTH = 1 << MAIN_ADDR;
   localparam int CH_DEPTH   = 1 << CH_ADDR;
   localparam int CNT_MOD    = 1 << CNT_W;

   logic clk, reset_L, init, push, req;
   logic [CH_ADDR:0]        th_almost_full, th_almost_empty;
   logic [DS-1:0]           data_in;
   logic [NUM_CH-1:0]       pop, valid_out, almost_full, almost_empty;
   logic [NUM_CH*DS-1:0]    data_out;
   logic                    main_full, valid_cont, idle, error;
   logic [CH_BITS-1:0]      idx;
   logic [CNT_W-1:0]        data_out_cont;

   trans_layer_n #(.DATA_SIZE(DS), .NUM_CH(NUM_CH), .CH_BITS(CH_BITS),
                   .MAIN_ADDR(MAIN_ADDR), .CH_ADDR(CH_ADDR), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset_L(reset_L), .init(init),
      .th_almost_full(th_almost_full), .th_almost_empty(th_almost_empty),
      .data_in(data_in), .push(push), .pop(pop),
      .data_out(data_out), .valid_out(valid_out),
      .almost_full(almost_full), .almost_empty(almost_empty), .main_full(main_full),
      .req(req), .idx(idx), .data_out_cont(data_out_cont), .valid_cont(valid_cont),
      .idle(idle), .error(error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   bit mon_en = 1'b0;

   // Reference model: plain queues and integers following the block's rules.
   typedef enum {M_RESET, M_INIT, M_IDLE, M_ACTIVE, M_ERROR} mst_e;
   mst_e          m_st;
   logic [DS-1:0] m_main [$];
   logic [DS-1:0] m_eg [NUM_CH][$];
   int            m_cnt [NUM_CH];
   int            m_th_af, m_th_ae;
   logic [DS-1:0] m_dout [NUM_CH];
   int            m_cont_out;
   logic [DS-1:0] exp_pop [NUM_CH][$];
   int            exp_cont [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit model_empty();
      bit e = (m_main.size() == 0);
      for (int i = 0; i < NUM_CH; i++) if (m_eg[i].size() != 0) e = 1'b0;
      return e;
   endfunction

   function automatic logic [NUM_CH-1:0] nonempty_mask();
      logic [NUM_CH-1:0] m = '0;
      for (int i = 0; i < NUM_CH; i++) m[i] = (m_eg[i].size() != 0);
      return m;
   endfunction

   task automatic model_edge();
      bit bad, rt, was_full;
      int d;
      if (!reset_L) begin
         m_st = M_RESET;
         m_main.delete();
         for (int i = 0; i < NUM_CH; i++) begin
            m_eg[i].delete();
            m_cnt[i]  = 0;
            m_dout[i] = '0;
         end
         m_th_af = 0; m_th_ae = 0; m_cont_out = 0;
         return;
      end
      case (m_st)
         M_RESET: m_st = M_INIT;
         M_INIT: begin
            m_th_af = th_almost_full;
            m_th_ae = th_almost_empty;
            if (!init) m_st = M_IDLE;
         end
         M_IDLE, M_ACTIVE: begin
            was_full = (m_main.size() == MAIN_DEPTH);
            bad = push && was_full;
            for (int i = 0; i < NUM_CH; i++) if (pop[i] && m_eg[i].size() == 0) bad = 1'b1;
            rt = 1'b0;
            d  = 0;
            if (m_main.size() > 0) begin
               d  = int'(m_main[0] >> (DS - CH_BITS));
               rt = (m_eg[d].size() < CH_DEPTH) && (m_eg[d].size() < m_th_af);
            end
            if (m_st == M_IDLE && req) begin
               m_cont_out = m_cnt[idx];
               exp_cont.push_back(m_cnt[idx]);
            end
            for (int i = 0; i < NUM_CH; i++) begin
               if (pop[i] && m_eg[i].size() != 0) begin
                  m_dout[i] = m_eg[i].pop_front();
                  exp_pop[i].push_back(m_dout[i]);
                  m_cnt[i] = (m_cnt[i] + 1) % CNT_MOD;
               end
            end
            if (rt) m_eg[d].push_back(m_main.pop_front());
            if (push && !was_full) m_main.push_back(data_in);
            if (bad)               m_st = M_ERROR;
            else if (init)         m_st = M_INIT;
            else if (model_empty()) m_st = M_IDLE;
            else                   m_st = M_ACTIVE;
         end
         default: ;
      endcase
   endtask

   task automatic step(input bit rst, input bit ini, input bit psh, input logic [DS-1:0] din,
                       input logic [NUM_CH-1:0] pp, input bit rq, input logic [CH_BITS-1:0] ix);
      reset_L = rst; init = ini; push = psh; data_in = din; pop = pp; req = rq; idx = ix;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle_step();
      step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
   endtask

   task automatic push_word(input logic [DS-1:0] w);
      step(1'b1, 1'b0, 1'b1, w, '0, 1'b0, '0);
   endtask

   task automatic do_reset(input int af, input int ae);
      th_almost_full  = (CH_ADDR+1)'(af);
      th_almost_empty = (CH_ADDR+1)'(ae);
      step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
      mon_en = 1'b1;
      step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
      step(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, '0);
      step(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, '0);
      idle_step();
   endtask

   task automatic send(input int ch, input int n);
      logic [CH_BITS-1:0] c;
      c = CH_BITS'(ch);
      for (int k = 0; k < n; k++) push_word({c, (DS-CH_BITS)'($urandom)});
   endtask

   task automatic drain();
      int n = 0;
      while (!(model_empty() && m_st == M_IDLE) && n < 300) begin
         step(1'b1, 1'b0, 1'b0, '0, nonempty_mask(), 1'b0, '0);
         n++;
      end
      if (n >= 300) begin
         n_chk++; n_fail++;
         $display("FAIL drain_bound: model still busy after %0d cycles, expected empty", n);
      end
      check("drain_idle", idle, 1'b1);
   endtask

   // Monitor: scoreboard pops on every valid, plus per-cycle status comparisons.
   always @(negedge clk) begin
      bit exp_v;
      logic [NUM_CH*DS-1:0] dv;
      logic [NUM_CH-1:0] af_e, ae_e;
      if (mon_en) begin
         for (int i = 0; i < NUM_CH; i++) begin
            exp_v = (exp_pop[i].size() != 0);
            check("valid_out", valid_out[i], exp_v);
            if (valid_out[i] && exp_v) check("pop_data", data_out[i*DS +: DS], exp_pop[i].pop_front());
            exp_pop[i].delete();
            dv[i*DS +: DS] = m_dout[i];
            af_e[i] = (m_st != M_RESET) && (m_eg[i].size() >= m_th_af);
            ae_e[i] = (m_eg[i].size() <= m_th_ae);
         end
         exp_v = (exp_cont.size() != 0);
         check("valid_cont", valid_cont, exp_v);
         if (valid_cont && exp_v) check("cont_data", data_out_cont, exp_cont.pop_front());
         exp_cont.delete();
         check("data_out_hold", data_out, dv);
         check("cont_hold", data_out_cont, m_cont_out);
         check("almost_full", almost_full, af_e);
         check("almost_empty", almost_empty, ae_e);
         check("main_full", main_full, m_main.size() == MAIN_DEPTH);
         check("idle", idle, m_st == M_IDLE);
         check("error", error, m_st == M_ERROR);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NUM_CH-1:0] pp;
      logic [DS-1:0] din;
      bit psh, rq, ini;
      logic [CH_BITS-1:0] ix;

      // Reset and init
      do_reset(3, 1);
      check("init_error", error, 1'b0);
      check("init_idle", idle, 1'b1);
      check("init_ae", almost_empty, 4'hF);
      check("init_dout", data_out, '0);

      // Minimum latency: push at k, pop at k+2
      push_word(12'h005);
      idle_step();
      step(1'b1, 1'b0, 1'b0, '0, 4'b0001, 1'b0, '0);
      check("lat_valid", valid_out, 4'b0001);
      check("lat_data", data_out[DS-1:0], 12'h005);

      // Routing to all four channels
      push_word(12'h005); push_word(12'h40A); push_word(12'h80F); push_word(12'hC01);
      idle_step();
      step(1'b1, 1'b0, 1'b0, '0, 4'hF, 1'b0, '0);
      check("route_valid", valid_out, 4'hF);
      check("route_data", data_out, {12'hC01, 12'h80F, 12'h40A, 12'h005});
      drain();

      // Backpressure with th_almost_full = 2
      do_reset(2, 1);
      push_word(12'h401); push_word(12'h402); push_word(12'h403); push_word(12'h404);
      push_word(12'h805);
      repeat (6) idle_step();
      check("bp_af1", almost_full[1], 1'b1);
      check("bp_ae2", almost_empty[2], 1'b1);
      check("bp_active", idle, 1'b0);
      step(1'b1, 1'b0, 1'b0, '0, 4'b0010, 1'b0, '0);
      check("bp_pop_valid", valid_out, 4'b0010);
      check("bp_pop_data", data_out[DS +: DS], 12'h401);
      repeat (2) idle_step();
      drain();

      // Counter read and wrap on channel 2
      do_reset(3, 1);
      send(2, 3);
      drain();
      step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 2'd2);
      check("cnt_valid", valid_cont, 1'b1);
      check("cnt_value", data_out_cont, 6'd3);
      idle_step();
      check("cnt_valid_drop", valid_cont, 1'b0);
      check("cnt_hold", data_out_cont, 6'd3);
      for (int b = 0; b < 31; b++) begin
         send(2, 2);
         drain();
      end
      step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 2'd2);
      check("cnt_wrap", data_out_cont, 6'd1);

      // Randomised traffic with burst and drain phases, occasional re-init
      do_reset($urandom_range(1, CH_DEPTH), $urandom_range(0, CH_DEPTH));
      for (int c = 0; c < 600; c++) begin
         psh = ((c / 24) % 2 == 0) && ($urandom_range(0, 9) < 6) && (m_main.size() < MAIN_DEPTH);
         din = DS'($urandom);
         pp  = '0;
         for (int i = 0; i < NUM_CH; i++)
            if (m_eg[i].size() != 0 && $urandom_range(0, 1) == 1) pp[i] = 1'b1;
         rq  = ($urandom_range(0, 3) == 0);
         ix  = CH_BITS'($urandom);
         ini = ($urandom_range(0, 63) == 0);
         if (ini) begin
            th_almost_full  = (CH_ADDR+1)'($urandom_range(1, CH_DEPTH));
            th_almost_empty = (CH_ADDR+1)'($urandom_range(0, CH_DEPTH));
         end
         step(1'b1, ini, psh, din, pp, rq, ix);
      end
      drain();

      // Reset with five words queued
      send(0, 5);
      step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
      check("mid_rst_full", main_full, 1'b0);
      check("mid_rst_ae", almost_empty, 4'hF);
      check("mid_rst_valid", valid_out, 4'h0);
      check("mid_rst_idle", idle, 1'b0);
      step(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, '0);
      check("mid_rst_init", idle, 1'b0);
      idle_step();
      check("mid_rst_idle2", idle, 1'b1);
      for (int i = 0; i < NUM_CH; i++) begin
         step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, CH_BITS'(i));
         check("mid_rst_cnt", data_out_cont, 6'd0);
      end

      // Error: ninth push into a full, unroutable main FIFO
      do_reset(0, 0);
      for (int k = 0; k < MAIN_DEPTH; k++) push_word(DS'($urandom));
      check("err_full", main_full, 1'b1);
      check("err_not_yet", error, 1'b0);
      push_word(12'h123);
      check("err_push", error, 1'b1);
      step(1'b1, 1'b0, 1'b1, 12'h456, 4'hF, 1'b1, '0);
      check("err_sticky", error, 1'b1);
      check("err_no_pop", valid_out, 4'h0);
      check("err_still_full", main_full, 1'b1);

      // Error: pop on empty egress
      do_reset(3, 1);
      step(1'b1, 1'b0, 1'b0, '0, 4'b0001, 1'b0, '0);
      check("err_pop", error, 1'b1);
      check("err_pop_valid", valid_out, 4'h0);
      idle_step();

      mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
